bank_wr_ctrl: RTL and testbench

//  - Write-side controller directly downstream of the lane-select/rotate interface stage.
//  - Drives that stage's SEL_PERMW rotation, takes its four rotated 64-bit lanes Q0..Q3 and

---
 rtl/bank_wr_ctrl_if.sv | 31 +++
 rtl/bank_wr_ctrl.sv | 109 ++++++++++
 tb/tb_bank_wr_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_wr_ctrl_if.sv
// Lane/bank bus between the rotate stage, the write controller and the SRAM banks.
// The controller takes the slave side; the environment (rotate stage + banks) takes master.
interface bank_wr_ctrl_if #(
    parameter int unsigned Dw = 64,
    parameter int unsigned Aw = 8
) ();
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    sel_permw;
    logic [Dw-1:0] q0;
    logic [Dw-1:0] q1;
    logic [Dw-1:0] q2;
    logic [Dw-1:0] q3;
    logic          bank_stall;
    logic [3:0]    we;
    logic [Aw-1:0] waddr;
    logic [Dw-1:0] wdata0;
    logic [Dw-1:0] wdata1;
    logic [Dw-1:0] wdata2;
    logic [Dw-1:0] wdata3;

    modport master (
        output in_valid, q0, q1, q2, q3, bank_stall,
        input  in_ready, sel_permw, we, waddr, wdata0, wdata1, wdata2, wdata3
    );

    modport slave (
        input  in_valid, q0, q1, q2, q3, bank_stall,
        output in_ready, sel_permw, we, waddr, wdata0, wdata1, wdata2, wdata3
    );
endinterface

// File: rtl/bank_wr_ctrl.sv
// Frame write controller: drives the lane rotation, registers rotated lanes into four banks
// at a common address, and signals frame completion with a one-cycle done pulse.
module bank_wr_ctrl #(
    parameter int unsigned Dw    = 64,
    parameter int unsigned Depth = 256,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [3:0]   skew_sh_i,
    output logic         busy_o,
    output logic         done_o,
    bank_wr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [Aw-1:0]          cnt_q, cnt_d;
    logic [3:0]             skew_q, skew_d;
    logic [3:0]             we_q, we_d;
    logic [Aw-1:0]          waddr_q, waddr_d;
    logic [3:0][Dw-1:0]     wdata_q, wdata_d;

    logic                   in_ready;
    logic                   accept;
    logic                   busy;
    logic                   done;
    logic [1:0]             sel;
    logic [Aw-1:0]          cnt_shifted;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        skew_d      = skew_q;
        we_d        = 4'h0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        sel         = 2'b00;
        // Shifts of Aw or more clear every bit, so large skews give a constant rotation of 0.
        cnt_shifted = cnt_q >> skew_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    skew_d  = skew_sh_i;
                end
            end
            StRun: begin
                busy     = 1'b1;
                in_ready = ~bus.bank_stall;
                sel      = cnt_shifted[1:0];
                accept   = bus.in_valid & in_ready;
                if (accept) begin
                    we_d    = 4'hF;
                    waddr_d = cnt_q;
                    wdata_d = {bus.q3, bus.q2, bus.q1, bus.q0};
                    cnt_d   = cnt_q + Aw'(1);
                    if (cnt_q == Aw'(Depth - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            skew_q  <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sel_permw = sel;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata0    = wdata_q[0];
    assign bus.wdata1    = wdata_q[1];
    assign bus.wdata2    = wdata_q[2];
    assign bus.wdata3    = wdata_q[3];
    assign busy_o        = busy;
    assign done_o        = done;

endmodule

// File: tb/tb_bank_wr_ctrl.sv
// Bench for bank_wr_ctrl: frame-level reference model checked every cycle, plus directed
// frames with literal expectations for rotation order, addresses, write counts and done timing.
module tb_bank_wr_ctrl;
    localparam int unsigned Dw    = 64;
    localparam int unsigned Depth = 8;
    localparam int unsigned Aw    = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] skew_sh = 4'd0;
    logic       busy;
    logic       done;

    bank_wr_ctrl_if #(.Dw(Dw), .Aw(Aw)) bus ();

    bank_wr_ctrl #(.Dw(Dw), .Depth(Depth), .Aw(Aw)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .skew_sh_i(skew_sh),
        .busy_o   (busy),
        .done_o   (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model: running flag, beats taken, and the last bank write.
    bit                 m_run      = 1'b0;
    bit                 m_done_now = 1'b0;
    int                 m_beats    = 0;
    int                 m_skew     = 0;
    logic [3:0]         m_we       = 4'h0;
    int                 m_waddr    = 0;
    logic [3:0][63:0]   m_wdata    = '0;
    wire                m_acc      = m_run && !bus.bank_stall && bus.in_valid;

    function automatic int exp_sel();
        if (!m_run || m_skew >= int'(Aw)) return 0;
        return (m_beats / (1 << m_skew)) % 4;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run      <= 1'b0;
            m_done_now <= 1'b0;
            m_beats    <= 0;
            m_skew     <= 0;
            m_we       <= 4'h0;
            m_waddr    <= 0;
            m_wdata    <= '0;
        end else begin
            m_we <= m_acc ? 4'hF : 4'h0;
            if (m_acc) begin
                m_waddr <= m_beats;
                m_wdata <= {bus.q3, bus.q2, bus.q1, bus.q0};
            end
            if (m_done_now) begin
                m_done_now <= 1'b0;
            end else if (!m_run) begin
                if (start) begin
                    m_run   <= 1'b1;
                    m_beats <= 0;
                    m_skew  <= int'(skew_sh);
                end
            end else if (m_acc) begin
                if (m_beats == Depth - 1) begin
                    m_run      <= 1'b0;
                    m_done_now <= 1'b1;
                    m_beats    <= 0;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end
        end
    end

    // Logs and scoreboard of accepted lane-0 data, consumed by the directed checks.
    bit          chk_en     = 1'b0;
    logic [63:0] sb[$];
    int          sel_log[$];
    int          addr_log[$];
    int          wcount     = 0;
    int          done_count = 0;
    int          done_addr  = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("we", 64'(bus.we), 64'(m_we));
            check("waddr", 64'(bus.waddr), 64'(m_waddr));
            check("wdata0", bus.wdata0, m_wdata[0]);
            check("wdata1", bus.wdata1, m_wdata[1]);
            check("wdata2", bus.wdata2, m_wdata[2]);
            check("wdata3", bus.wdata3, m_wdata[3]);
            check("done", 64'(done), 64'(m_done_now));
            check("busy", 64'(busy), 64'(m_run | m_done_now));
            check("in_ready", 64'(bus.in_ready), 64'(m_run & ~bus.bank_stall));
            check("sel_permw", 64'(bus.sel_permw), 64'(exp_sel()));
            if (bus.we == 4'hF) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=write required=no_write at %0t", $time);
                end else begin
                    check("sb_wdata0", bus.wdata0, sb.pop_front());
                end
                wcount++;
                addr_log.push_back(int'(bus.waddr));
                if (done) done_addr = int'(bus.waddr);
            end
            if (done) done_count++;
            if (!rst_n) sb.delete();
            else if (m_acc) sb.push_back(bus.q0);
            if (rst_n && bus.in_ready && bus.in_valid) sel_log.push_back(int'(bus.sel_permw));
        end
    end

    int qseq = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        sel_log.delete();
        addr_log.delete();
        wcount     = 0;
        done_count = 0;
        done_addr  = -1;
    endtask

    task automatic drive_q();
        qseq++;
        bus.q0 = 64'hA000_0000_0000_0000 | 64'(qseq);
        bus.q1 = 64'hB100_0000_0000_0000 | 64'(qseq);
        bus.q2 = 64'hC200_0000_0000_0000 | 64'(qseq);
        bus.q3 = 64'hD300_0000_0000_0000 | 64'(qseq);
    endtask

    task automatic run_frame(input logic [3:0] sh, input logic [31:0] stall_at,
                             input logic [31:0] gap_at, input logic [31:0] start_at,
                             input bit start_in_done);
        bit finished = 1'b0;
        clear_logs();
        start   = 1'b1;
        skew_sh = sh;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            bus.in_valid   = !gap_at[k];
            bus.bank_stall = stall_at[k];
            start          = start_at[k];
            drive_q();
            tick();
            if (done) begin
                finished = 1'b1;
                break;
            end
        end
        bus.in_valid   = 1'b0;
        bus.bank_stall = 1'b0;
        start          = start_in_done;
        tick();
        start = 1'b0;
        check("frame_finished", 64'(finished), 64'd1);
    endtask

    task automatic check_frame_writes(input string tag);
        check({tag, "_wcount"}, 64'(wcount), 64'd8);
        check({tag, "_done_count"}, 64'(done_count), 64'd1);
        check({tag, "_done_addr"}, 64'(done_addr), 64'd7);
        check({tag, "_addr_len"}, 64'(addr_log.size()), 64'd8);
        for (int i = 0; i < addr_log.size() && i < 8; i++) begin
            check({tag, "_addr"}, 64'(addr_log[i]), 64'(i));
        end
    endtask

    task automatic check_sel(input string tag, input int exp[8]);
        check({tag, "_sel_len"}, 64'(sel_log.size()), 64'd8);
        for (int i = 0; i < sel_log.size() && i < 8; i++) begin
            check({tag, "_sel"}, 64'(sel_log[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        int sel_s0[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int sel_s1[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int sel_s5[8] = '{0, 0, 0, 0, 0, 0, 0, 0};

        bus.in_valid   = 1'b1;
        bus.bank_stall = 1'b0;
        start          = 1'b1;
        rst_n          = 1'b0;
        drive_q();

        // Reset held two cycles with valid and start asserted.
        tick();
        chk_en = 1'b1;
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("rst2_we", 64'(bus.we), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);
        check("rst2_sel", 64'(bus.sel_permw), 64'd0);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();

        run_frame(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_frame_writes("f_skew0");
        check_sel("f_skew0", sel_s0);
        tick();

        run_frame(4'd1, 32'h0, 32'h0, 32'h0, 1'b0);
        check_frame_writes("f_skew1");
        check_sel("f_skew1", sel_s1);
        tick();

        run_frame(4'd5, 32'h0, 32'h0, 32'h0, 1'b0);
        check_frame_writes("f_skew5");
        check_sel("f_skew5", sel_s5);
        tick();

        // Stall on cycles 2,3 and a valid gap on cycle 5 only delay the frame.
        run_frame(4'd0, 32'h0000_000C, 32'h0000_0020, 32'h0, 1'b0);
        check_frame_writes("f_stall");
        check_sel("f_stall", sel_s0);
        check("f_stall_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // START mid-frame and in the done cycle must not restart anything.
        run_frame(4'd0, 32'h0, 32'h0, 32'h0000_0010, 1'b1);
        tick();
        tick();
        check("restart_busy", 64'(busy), 64'd0);
        check("restart_wcount", 64'(wcount), 64'd8);
        check("restart_done_count", 64'(done_count), 64'd1);
        run_frame(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_frame_writes("f_after_restart");
        tick();

        // Reset after three accepted beats abandons the frame.
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            drive_q();
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("midrst_we", 64'(bus.we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        check("midrst_done_count", 64'(done_count), 64'd0);
        run_frame(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_frame_writes("f_after_rst");
        check_sel("f_after_rst", sel_s0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
